// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x5 matrix keypad scan with debounce and newkey/keycode output; KEYPAD_REPEAT_EN adds auto-repeat.
// Latency: 2-cycle row sync, then newkey one cycle after the DEBOUNCE_SCANS-th matching sample of the column.
// Backpressure: none; newkey is a one-cycle pulse and the consumer must take it when it fires.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_PERIOD  = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows_n,
    output logic [4:0] col_n,
    output logic       newkey,
    output logic [4:0] keycode
);
    localparam int CNT_MAX0 = (DEBOUNCE_SCANS > REPEAT_DELAY) ? DEBOUNCE_SCANS : REPEAT_DELAY;
    localparam int CNT_MAX  = (CNT_MAX0 > REPEAT_PERIOD) ? CNT_MAX0 : REPEAT_PERIOD;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    logic [3:0]       rows_s1_q;
    logic [3:0]       rows_s2_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [2:0]       col_q;
    logic [2:0]       col_d;
    logic [4:0]       col_n_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       cand_col_q;
    logic [1:0]       cand_row_q;
    logic             newkey_q;
    logic [4:0]       keycode_q;

    logic             sample_pt;
    logic [3:0]       row_low;
    logic             one_low;
    logic [1:0]       row_idx;
    logic             on_cand;
    logic             same_row;
    logic             held_low;
    logic [CNT_W-1:0] cnt_inc;
    logic [4:0]       code_now;
    logic [4:0]       code_cand;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rows_s1_q <= 4'hF;
            rows_s2_q <= 4'hF;
        end else begin
            rows_s1_q <= rows_n;
            rows_s2_q <= rows_s1_q;
        end
    end

    always_comb begin
        row_low   = ~rows_s2_q;
        sample_pt = (div_q == DIV_LAST);
        // Zero or several rows low are both "no key": multi-row lows are ghost candidates.
        one_low   = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
        row_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (row_low[i]) row_idx = 2'(i);
        end
        on_cand   = (col_q == cand_col_q);
        same_row  = one_low && (row_idx == cand_row_q);
        held_low  = row_low[cand_row_q];
        cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        code_now  = {col_q, 2'b00} + {3'b000, row_idx};
        code_cand = {cand_col_q, 2'b00} + {3'b000, cand_row_q};
    end

    always_comb begin
        div_d = div_q + DIV_W'(1);
        col_d = col_q;
        if (sample_pt) begin
            div_d = '0;
            col_d = (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            col_q   <= 3'd0;
            col_n_q <= 5'b11110;
        end else begin
            div_q   <= div_d;
            col_q   <= col_d;
            col_n_q <= ~(5'b00001 << col_d);
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [CNT_W-1:0] rpt_cnt_q;
    logic             rpt_first_q;
    logic [CNT_W-1:0] rpt_inc;
    logic [CNT_W-1:0] rpt_lim;

    always_comb begin
        rpt_inc = (rpt_cnt_q == {CNT_W{1'b1}}) ? rpt_cnt_q : rpt_cnt_q + CNT_W'(1);
        rpt_lim = rpt_first_q ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_PERIOD);
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            cand_col_q  <= 3'd0;
            cand_row_q  <= 2'd0;
            newkey_q    <= 1'b0;
            keycode_q   <= 5'd0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
`endif
        end else begin
            newkey_q <= 1'b0;
            if (sample_pt) begin
                case (state_q)
                    SCAN: begin
                        if (one_low) begin
                            cand_col_q <= col_q;
                            cand_row_q <= row_idx;
                            if (DEBOUNCE_SCANS == 1) begin
                                state_q   <= HELD;
                                cnt_q     <= '0;
                                newkey_q  <= 1'b1;
                                keycode_q <= code_now;
`ifdef KEYPAD_REPEAT_EN
                                rpt_cnt_q   <= '0;
                                rpt_first_q <= 1'b1;
`endif
                            end else begin
                                state_q <= DEBOUNCE;
                                cnt_q   <= CNT_W'(1);
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (on_cand) begin
                            if (!same_row) begin
                                state_q <= SCAN;
                                cnt_q   <= '0;
                            end else if (cnt_inc >= DEB_LIM) begin
                                state_q   <= HELD;
                                cnt_q     <= '0;
                                newkey_q  <= 1'b1;
                                keycode_q <= code_cand;
`ifdef KEYPAD_REPEAT_EN
                                rpt_cnt_q   <= '0;
                                rpt_first_q <= 1'b1;
`endif
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end
                    end
                    HELD: begin
                        // Other columns are ignored here: no rollover while a key is held.
                        if (on_cand) begin
                            if (held_low) begin
                                cnt_q <= '0;
`ifdef KEYPAD_REPEAT_EN
                                if (rpt_inc >= rpt_lim) begin
                                    newkey_q    <= 1'b1;
                                    keycode_q   <= code_cand;
                                    rpt_cnt_q   <= '0;
                                    rpt_first_q <= 1'b0;
                                end else begin
                                    rpt_cnt_q <= rpt_inc;
                                end
`endif
                            end else begin
`ifdef KEYPAD_REPEAT_EN
                                rpt_cnt_q   <= '0;
                                rpt_first_q <= 1'b1;
`endif
                                if (cnt_inc >= DEB_LIM) begin
                                    state_q <= SCAN;
                                    cnt_q   <= '0;
                                end else begin
                                    cnt_q <= cnt_inc;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign col_n   = col_n_q;
    assign newkey  = newkey_q;
    assign keycode = keycode_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model driving rows_n from col_n.
// Cycle numbers count rising edges since reset release; scan = 20 cycles, column dwell = 4.
module tb_keypad_scanner;
    logic        clock;
    logic        reset;
    logic [3:0]  rows_n;
    logic [4:0]  col_n;
    logic        newkey;
    logic [4:0]  keycode;

    logic [19:0] keys;
    int          cyc;
    int          pulse_cnt;
    int          last_pulse_cyc;
    int          last_code;
    int          vectors;
    int          miscompares;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3),
        .REPEAT_DELAY   (5),
        .REPEAT_PERIOD  (2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rows_n  (rows_n),
        .col_n   (col_n),
        .newkey  (newkey),
        .keycode (keycode)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Key index 4*col+row pulls its row low while its column is driven.
    always_comb begin
        rows_n = 4'hF;
        for (int c = 0; c < 5; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col_n[c] && keys[4*c+r]) rows_n[r] = 1'b0;
            end
        end
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        pulse_cnt      = 0;
        last_pulse_cyc = -1;
        last_code      = -1;
        forever begin
            @(posedge clock);
            #1;
            if (newkey === 1'b1) begin
                pulse_cnt++;
                last_pulse_cyc = cyc;
                last_code      = int'(keycode);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 5000) begin
            @(negedge clock);
            guard++;
        end
        chk("wait_cyc", cyc, n);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        keys        = '0;
`ifndef KEYPAD_REPEAT_EN
        keys[9]     = 1'b1;
`endif
        repeat (3) @(negedge clock);
        chk("rst_col_n", col_n, 5'b11110);
        chk("rst_newkey", newkey, 0);
        chk("rst_keycode", keycode, 0);
        reset = 1'b1;

        wait_cyc(17);
        chk("col_n_col4", col_n, 5'b01111);
        wait_cyc(21);
        chk("col_n_wrap", col_n, 5'b11110);

`ifndef KEYPAD_REPEAT_EN
        wait_cyc(51);
        chk("press9_early", pulse_cnt, 0);
        wait_cyc(52);
        chk("press9_newkey", newkey, 1);
        chk("press9_keycode", keycode, 9);
        wait_cyc(53);
        chk("press9_one_cycle", newkey, 0);
        chk("press9_count", pulse_cnt, 1);
        chk("press9_latency", last_pulse_cyc, 52);

        wait_cyc(60);
        keys[19] = 1'b1;
        wait_cyc(260);
        chk("hold_no_repeat", pulse_cnt, 1);

        keys = '0;
        wait_cyc(320);
        keys[19] = 1'b1;
        wait_cyc(390);
        chk("press19_count", pulse_cnt, 2);
        chk("press19_latency", last_pulse_cyc, 380);
        chk("press19_code", last_code, 19);

        wait_cyc(400);
        keys = '0;
        wait_cyc(480);
        keys[12] = 1'b1;
        keys[14] = 1'b1;
        wait_cyc(680);
        chk("ghost_count", pulse_cnt, 2);
        chk("ghost_keycode", keycode, 19);
        keys = '0;

        wait_cyc(760);
        keys[9] = 1'b1;
        wait_cyc(795);
        reset = 1'b0;
        #1;
        chk("midrst_newkey", newkey, 0);
        chk("midrst_keycode", keycode, 0);
        chk("midrst_col_n", col_n, 5'b11110);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        wait_cyc(51);
        chk("midrst_no_pulse", pulse_cnt, 2);
        wait_cyc(53);
        chk("fresh9_count", pulse_cnt, 3);
        chk("fresh9_latency", last_pulse_cyc, 52);
        chk("fresh9_code", last_code, 9);

        wait_cyc(60);
        keys = '0;
        wait_cyc(140);
        for (int i = 0; i < 40; i++) begin
            keys[0] = ((i / 3) % 2 == 0);
            @(negedge clock);
        end
        keys[0] = 1'b1;
        chk("bounce_no_pulse", pulse_cnt, 3);
        wait_cyc(230);
        chk("bounce_count", pulse_cnt, 4);
        chk("bounce_latency", last_pulse_cyc, 224);
        chk("bounce_code", last_code, 0);
`else
        wait_cyc(20);
        keys[5] = 1'b1;
        wait_cyc(69);
        chk("rpt_first_count", pulse_cnt, 1);
        chk("rpt_first_cyc", last_pulse_cyc, 68);
        chk("rpt_first_code", last_code, 5);
        wait_cyc(169);
        chk("rpt_delay_count", pulse_cnt, 2);
        chk("rpt_delay_cyc", last_pulse_cyc, 168);
        wait_cyc(321);
        chk("rpt_period_count", pulse_cnt, 5);
        chk("rpt_period_cyc", last_pulse_cyc, 288);
        chk("rpt_keycode", keycode, 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
